// File: rtl/des_uart_dispatch.sv
// Queues DES ciphertext blocks, launches them one at a time over the uart2_top
// loopback link, and checks that each returned block matches the one sent.
//
// state | meaning
// IDLE  | waiting for a queued block; pops the FIFO head into data_in
// START | one-cycle fsm_start pulse, timeout timer loaded
// WAIT  | waiting for data_ready; timer counts down to the lost-block limit
module des_uart_dispatch #(
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [63:0] in_data,
   output logic        in_ready,
   output logic        fsm_start,
   output logic [63:0] data_in,
   input  logic        data_ready,
   input  logic [63:0] data_out,
   output logic        out_valid,
   output logic [63:0] out_data,
   output logic        busy,
   output logic [15:0] blocks_ok,
   output logic        err_mismatch,
   output logic        err_timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t        state_q, state_d;
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [TW-1:0] timer;
   logic          push, pop, match_hit, mismatch_hit, timeout_hit;

   assign in_ready = (count != FULL_CNT);
   assign push     = in_valid && in_ready;
   assign busy     = (state_q != IDLE);

   always_comb begin
      state_d      = state_q;
      pop          = 1'b0;
      fsm_start    = 1'b0;
      match_hit    = 1'b0;
      mismatch_hit = 1'b0;
      timeout_hit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               state_d = START;
            end
         end
         START: begin
            fsm_start = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            // a return in the final timeout cycle still counts as delivered
            if (data_ready) begin
               if (data_out == data_in) match_hit = 1'b1;
               else                     mismatch_hit = 1'b1;
               state_d = IDLE;
            end else if (timer == '0) begin
               timeout_hit = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         data_in      <= '0;
         timer        <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         blocks_ok    <= '0;
         err_mismatch <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + AW'(1);
            data_in <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         // down-counter: T-1 loaded at START gives exactly T WAIT cycles
         if (fsm_start)
            timer <= TMO_LOAD;
         else if (state_q == WAIT && timer != '0)
            timer <= timer - TW'(1);
         out_valid <= match_hit;
         if (match_hit) begin
            out_data  <= data_in;
            blocks_ok <= blocks_ok + 16'd1;
         end
         if (mismatch_hit) err_mismatch <= 1'b1;
         if (timeout_hit)  err_timeout  <= 1'b1;
      end
   end

endmodule
